// File: rtl/exe_stage_pkg.sv
// Shared constants and types for the MIPS execute stage.
// ALU command encodings, mul/div FSM states, datapath width.
package exe_stage_pkg;

  localparam int EXE_WIDTH = 32;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;
  localparam logic [3:0] CMD_DIV = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/exe_stage_mul_div_unit.sv
// Iterative 32-step unsigned multiplier (shift-add) and
// restoring divider sharing one set of working registers.
module mul_div_unit
  import exe_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_result
);

  md_state_e   r_state;
  md_state_e   w_state_nx;
  logic [4:0]  r_cnt;
  logic        r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [32:0] r_acc;
  logic [31:0] r_result;

  logic [31:0] w_mul_acc;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [32:0] w_rem_nx;
  logic [31:0] w_q_nx;

  // r_acc: product (mul) or partial remainder (div).
  // r_a: shifting multiplicand (mul) or dividend/quotient (div).
  always_comb begin
    w_mul_acc = r_acc[31:0] + (r_b[0] ? r_a : 32'd0);
    w_rem_sh  = {r_acc[31:0], r_a[31]};
    w_ge      = (w_rem_sh >= {1'b0, r_b});
    w_rem_nx  = w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
    w_q_nx    = {r_a[30:0], w_ge};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    o_busy     = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_busy = i_start & ~i_rst;
        if (i_start) w_state_nx = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (r_cnt == 5'd0) w_state_nx = DONE;
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cnt <= 5'd31;
            r_op  <= i_op;
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
          end
        end
        RUN: begin
          if (r_op) begin
            r_acc <= w_rem_nx;
            r_a   <= w_q_nx;
          end else begin
            r_acc <= {1'b0, w_mul_acc};
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end
          if (r_cnt == 5'd0)
            r_result <= r_op ? w_q_nx : w_mul_acc;
          else
            r_cnt <= r_cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: combinational ALU, branch target adder,
// pass-through controls and bubble gating while mul/div runs.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int WIDTH = EXE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [WIDTH-1:0] PC_in,
  input  logic             Br_taken_in,
  input  logic [3:0]       EXE_CMD,
  input  logic             MEM_R_EN_in,
  input  logic             MEM_W_EN_in,
  input  logic             WB_EN_in,
  input  logic [4:0]       Dest_in,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] Br_addr,
  output logic             Br_taken,
  output logic [WIDTH-1:0] Reg2_out,
  output logic [4:0]       Dest,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic             WB_EN,
  output logic             Busy
);

  logic             w_is_md;
  logic             w_md_busy;
  logic [31:0]      w_md_result;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_alu;

  assign w_is_md = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIV);
  assign w_shamt = Val2[4:0];

  mul_div_unit u_md (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (w_is_md),
    .i_op     (EXE_CMD == CMD_DIV),
    .i_a      (Val1),
    .i_b      (Val2),
    .o_busy   (w_md_busy),
    .o_result (w_md_result)
  );

  always_comb begin
    w_alu = '0;
    unique case (EXE_CMD)
      CMD_ADD: w_alu = Val1 + Val2;
      CMD_SUB: w_alu = Val1 - Val2;
      CMD_AND: w_alu = Val1 & Val2;
      CMD_OR:  w_alu = Val1 | Val2;
      CMD_NOR: w_alu = ~(Val1 | Val2);
      CMD_XOR: w_alu = Val1 ^ Val2;
      CMD_SLL: w_alu = Val1 << w_shamt;
      CMD_SRA: w_alu = $unsigned($signed(Val1) >>> w_shamt);
      CMD_SRL: w_alu = Val1 >> w_shamt;
      default: w_alu = '0;
    endcase
  end

  // A frozen MUL/DIV command only reaches here un-stalled in DONE.
  assign ALU_result = w_is_md ? w_md_result : w_alu;
  assign Br_addr    = PC_in + (Val2 << 2);
  assign Br_taken   = Br_taken_in;
  assign Reg2_out   = Reg2;
  assign Dest       = Dest_in;
  assign Busy       = w_md_busy;
  assign MEM_R_EN   = MEM_R_EN_in & ~w_md_busy;
  assign MEM_W_EN   = MEM_W_EN_in & ~w_md_busy;
  assign WB_EN      = WB_EN_in & ~w_md_busy;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with an expected-result queue.
// Inputs change 1 time unit after posedge; outputs sampled at negedge.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] Val1, Val2, Reg2, PC_in;
  logic        Br_taken_in;
  logic [3:0]  EXE_CMD;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic [4:0]  Dest_in;
  logic [31:0] ALU_result, Br_addr, Reg2_out;
  logic        Br_taken;
  logic [4:0]  Dest;
  logic        MEM_R_EN, MEM_W_EN, WB_EN, Busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  exe_stage #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .Val1        (Val1),
    .Val2        (Val2),
    .Reg2        (Reg2),
    .PC_in       (PC_in),
    .Br_taken_in (Br_taken_in),
    .EXE_CMD     (EXE_CMD),
    .MEM_R_EN_in (MEM_R_EN_in),
    .MEM_W_EN_in (MEM_W_EN_in),
    .WB_EN_in    (WB_EN_in),
    .Dest_in     (Dest_in),
    .ALU_result  (ALU_result),
    .Br_addr     (Br_addr),
    .Br_taken    (Br_taken),
    .Reg2_out    (Reg2_out),
    .Dest        (Dest),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .WB_EN       (WB_EN),
    .Busy        (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed empty-queue expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk(tag, ALU_result, e);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b);
    EXE_CMD = cmd;
    Val1    = a;
    Val2    = b;
  endtask

  task automatic step_alu(input string tag, input logic [3:0] cmd,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    drive(cmd, a, b);
    sb_q.push_back(exp);
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk_pop(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input string tag, input logic [3:0] cmd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int nb;
    bit wb_bad;
    nb = 0;
    wb_bad = 0;
    drive(cmd, a, b);
    WB_EN_in = 1'b1;
    sb_q.push_back(exp);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Busy) break;
      nb++;
      if (WB_EN !== 1'b0) wb_bad = 1;
      @(posedge clk);
      #1;
    end
    chk({tag, "_busycycles"}, nb, 32'd33);
    chk({tag, "_wb_bubble"}, {31'd0, wb_bad}, 32'd0);
    chk({tag, "_wb_done"}, {31'd0, WB_EN}, 32'd1);
    chk_pop(tag);
    @(posedge clk);
    #1;
    WB_EN_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    Val1 = '0; Val2 = '0; Reg2 = '0; PC_in = '0;
    Br_taken_in = 1'b0; EXE_CMD = '0;
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; WB_EN_in = 1'b0;
    Dest_in = '0;
    @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_alu", ALU_result, 32'd0);
    chk("rst_en", {29'd0, MEM_R_EN, MEM_W_EN, WB_EN}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step_alu("add_wrap", CMD_ADD, 32'h7fffffff, 32'h1, 32'h80000000);
    step_alu("sub_neg", CMD_SUB, 32'h0, 32'h1, 32'hffffffff);
    step_alu("and", CMD_AND, 32'hf0f0_1234, 32'h0ff0_ffff, 32'h00f0_1234);
    step_alu("or", CMD_OR, 32'hf000_0001, 32'h0000_0100, 32'hf000_0101);
    step_alu("nor", CMD_NOR, 32'hf000_0000, 32'h0000_000f, 32'h0fff_fff0);
    step_alu("xor", CMD_XOR, 32'hffff_0000, 32'hff00_ff00, 32'h00ff_ff00);
    step_alu("sll", CMD_SLL, 32'h0000_0003, 32'd31, 32'h8000_0000);
    step_alu("sra", CMD_SRA, 32'h8000_0000, 32'd4, 32'hf800_0000);
    step_alu("srl", CMD_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    step_alu("srl_36", CMD_SRL, 32'h8000_0000, 32'd36, 32'h0800_0000);
    step_alu("undef", 4'b1111, 32'h1234_5678, 32'h1, 32'h0);

    // Pass-through and branch checks
    drive(CMD_ADD, 32'h1, 32'hffff_fffe);
    PC_in = 32'h10; Br_taken_in = 1'b1; Reg2 = 32'hdead_beef;
    Dest_in = 5'd17; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b1;
    WB_EN_in = 1'b1;
    @(negedge clk);
    chk("br_addr", Br_addr, 32'h0000_0008);
    chk("br_taken1", {31'd0, Br_taken}, 32'd1);
    chk("reg2_out", Reg2_out, 32'hdead_beef);
    chk("dest", {27'd0, Dest}, 32'd17);
    chk("en_pass", {29'd0, MEM_R_EN, MEM_W_EN, WB_EN}, 32'd7);
    Br_taken_in = 1'b0;
    #1;
    chk("br_taken0", {31'd0, Br_taken}, 32'd0);
    @(posedge clk);
    #1;
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; WB_EN_in = 1'b0;

    run_md("mul", CMD_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000);
    run_md("mul2", CMD_MUL, 32'd12345, 32'd6789, 32'd12345 * 32'd6789);
    run_md("div", CMD_DIV, 32'd100, 32'd7, 32'd14);
    run_md("div0", CMD_DIV, 32'h1234_5678, 32'd0, 32'hffff_ffff);
    run_md("div_big", CMD_DIV, 32'hffff_ffff, 32'h8000_0001, 32'd1);
    // Back-to-back: DIV follows MUL without an intervening command
    run_md("b2b_mul", CMD_MUL, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0001);
    run_md("b2b_div", CMD_DIV, 32'd1000000, 32'd3, 32'd333333);

    // Reset during RUN abandons the op
    drive(CMD_MUL, 32'd5, 32'd6);
    sb_q.push_back(32'd30);
    @(negedge clk);
    chk("abort_busy0", {31'd0, Busy}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_run", {31'd0, Busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step_alu("post_rst_add", CMD_ADD, 32'd40, 32'd2, 32'd42);
    run_md("post_rst_mul", CMD_MUL, 32'd5, 32'd6, 32'd30);

    chk("queue_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage MIPS pipeline, sitting between the ID/EX stage register and the EX/MEM stage register. It computes the ALU result and branch target from the operands and command latched by the ID/EX register. It also contains an iterative 32-cycle multiply/divide unit that stalls the front of the pipeline while it runs. While stalled, it emits bubbles downstream.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- Val1  in  32  first ALU operand.
- Val2  in  32  second ALU operand; also the shift amount (Val2[4:0]) and the branch offset.
- Reg2  in  32  store data for MEM stage.
- PC_in  in  32  PC+4 of the instruction.
- Br_taken_in  in  1  branch-taken decision from ID.
- EXE_CMD  in  4  ALU command.
- MEM_R_EN_in  in  1  memory read enable, passed through.
- MEM_W_EN_in  in  1  memory write enable, passed through.
- WB_EN_in  in  1  writeback enable, passed through.
- Dest_in  in  5  destination register, passed through.
- ALU_result  out  32  execute result.
- Br_addr  out  32  PC_in + (Val2 << 2), modulo 2^32.
- Br_taken  out  1  equals Br_taken_in; feeds the IF PC mux and the Flush signal.
- Reg2_out  out  32  equals Reg2.
- Dest  out  5  equals Dest_in.
- MEM_R_EN, MEM_W_EN, WB_EN  out  1 each  equal the inputs; forced to 0 while Busy=1.
- Busy  out  1  stall request; freezes PC, the IF/ID register and the ID/EX register.

## Operation
EXE_CMD encoding:
- ADD 0000
- SUB 0010
- AND 0100
- OR 0101
- NOR 0110
- XOR 0111
- SLL 1000
- SRA 1001
- SRL 1010
- MUL 1100
- DIV 1101
- All other codes: ALU_result = 0.

ALU rules:
- ADD and SUB: 32-bit wrap-around, no overflow flag.
- Shifts: shift Val1 by Val2[4:0].
- All non-MUL/DIV commands are purely combinational and have zero added latency.

MUL: unsigned shift-add; result is the low 32 bits of Val1*Val2.

DIV: unsigned restoring division; result is the quotient Val1/Val2. Val2 = 0 gives 32'hFFFFFFFF.

Multiply/divide FSM states are IDLE, RUN and DONE:
- IDLE, EXE_CMD is MUL or DIV: Busy=1 combinationally. At the clock edge, latch the operands and the op, set count=31, and go to RUN.
- RUN: Busy=1. Perform one iteration per cycle. When count=0, write the result register and go to DONE; otherwise decrement count.
- DONE: Busy=0 and ALU_result = result register. Go to IDLE unconditionally. The frozen MUL/DIV still present on the inputs in this cycle must not retrigger the FSM.
- IDLE, any other command: Busy=0 and ALU_result is combinational.

Other rules:
- Back-to-back MUL/DIV: the second op is seen in IDLE the cycle after DONE and starts normally.
- Br_taken and Br_addr are combinational from the inputs in every state.
- The bubble gating (MEM_R_EN, MEM_W_EN, WB_EN forced to 0) is the only effect of Busy on the outputs.

## Timing
- Reset (asynchronous) forces: state=IDLE, count=0, result register=0, latched operands=0.
- Consequently, while rst is high and with the inputs at 0: Busy=0, ALU_result=0, MEM_R_EN=MEM_W_EN=WB_EN=0.
- MUL/DIV arrives in cycle 0. Busy is high in cycles 0–32 (33 cycles). The result is valid in cycle 33 and is captured by the EX/MEM register at the end of cycle 33.
- Total MUL/DIV occupancy is 34 cycles. Every other command takes 1 cycle.
- Reset asserted mid-RUN: the op is abandoned, Busy drops immediately, and no result is produced.
- Flush from a younger branch cannot coincide with RUN, because the front end is frozen while Busy=1.

## Structure
- Shared package: EXE_CMD constants, the FSM state enum (IDLE, RUN, DONE) and the WIDTH constant.
- Sub-module mul_div_unit contains the FSM, the counter, the operand/remainder/product registers and the result register. It exposes start, op, a, b, busy and result.
- exe_stage contains the combinational ALU, the branch adder, the pass-through signals and the bubble gating.

## Test plan
- ADD 7fffffff+1 -> ALU_result 80000000. SUB 0-1 -> ffffffff. Busy stays 0.
- SRA Val1=80000000, Val2=4 -> f8000000. SRL gives 08000000. Val2=36 shifts by 4.
- MUL 0001_0000 * 0001_0001 -> 0001_0000 in cycle 33. Busy high for exactly 33 cycles. WB_EN=0 during cycles 0–32 and WB_EN=1 in cycle 33.
- DIV 100/7 -> 14. DIV x/0 -> ffffffff. Back-to-back MUL then DIV: each takes 34 cycles, with no retrigger in DONE.
- rst pulsed at RUN cycle 10 -> Busy=0 immediately. A subsequent ADD passes through in 1 cycle, and the next MUL gives the correct result.
- Branch: PC_in=00000010, Val2=fffffffe -> Br_addr 00000008, and Br_taken follows Br_taken_in.
